board_ctrl: RTL and testbench
=============================

// Module: board_ctrl
// PURPOSE
//  Game-board store and move-judging stage downstream of the game FSM. Drops the current player's
//  piece into the selected column on the FSM write strobe and reports busy (column full), win and
//  full back to the FSM. Provides a combinational cell read port for the VGA renderer.
//  Board geometry is Connect-4 style: gravity drop, with row 0 at the bottom.
// PARAMETERS
//  ROWS     6  board rows (1..8)
//  COLS     7  board columns (1..8)
//  WIN_LEN  4  contiguous same-player pieces needed to win (2..max(ROWS,COLS))
// PORTS
//  clk      in   1  system clock; all state updates on posedge
//  rst      in   1  reset, synchronous, active-high; clears board, counters and flags
//  col      in   3  selected column (cursor or random pick); values >= COLS are invalid
//  player   in   1  current player (0/1); piece code = player+1
//  w_e      in   1  write strobe from FSM, one cycle per move
//  busy     out  1  comb: col >= COLS, or height[col] == ROWS
//  win      out  1  registered, sticky: the last accepted move completed a line
//  winner   out  1  registered: player that made the winning move; valid only while win=1
//  full     out  1  registered: move count == ROWS*COLS
//  rd_row   in   3  VGA read row
//  rd_col   in   3  VGA read column
//  rd_cell  out  2  comb: 00 empty, 01 player0, 10 player1; 00 if rd_row/rd_col is out of range
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all cells 00, height[c]=0, move count=0, win=0, winner=0, full=0.
//    rst has priority over a simultaneous w_e.
//  - State
//    - board: ROWS*COLS x 2-bit register array.
//    - height[c]: 4-bit per column.
//    - moves: 7-bit counter.
//  - Move accepted in cycle N when w_e=1 && !busy && !win. Target row r = height[col].
//  - At posedge ending cycle N:
//    - cell[r][col] <= player+1
//    - height[col] += 1
//    - moves += 1
//    - win <= win | hit
//    - winner <= player, if hit
//    - full <= (moves+1 == ROWS*COLS)
//  - Latency: win, full and busy reflect the move in cycle N+1. This matches the FSM, which checks
//    win/full in the state that immediately follows its write state.
//  - hit: computed combinationally in cycle N on the pre-write board, treating (r,col) as owned by
//    player. Four axes through (r,col): horizontal, vertical, diagonal /, diagonal \.
//    - Per axis: 1 + same-player run in the + direction + same-player run in the - direction,
//      each run capped at WIN_LEN-1 and stopped at the board edge.
//    - hit = any axis count >= WIN_LEN.
//  - Ignored writes (no state change at all):
//    - w_e while busy (column full or invalid column);
//    - w_e after win=1 (board frozen until rst).
//  - w_e is level-sampled per cycle; holding it high over k cycles is k move attempts.
//  - Win and full in the same move: both flags set; the FSM treats either as game over.
//  - busy stays purely per-column after full; all columns read busy=1 once full=1.
//  - rd port never disturbs state. It is readable during and after a write, with the new value
//    from cycle N+1.
// TESTING
//  1. rst, then read all cells -> rd_cell=00 everywhere; win=0, full=0; busy=0 for col 0..6,
//     busy=1 for col=7.
//  2. player0 drops in col 3 four times (w_e pulses) -> cells (0..3,3)=01; win=1 and winner=0
//     from the cycle after the 4th w_e; a 5th w_e is ignored (height[3] stays 4).
//  3. Alternate players six times into col 0 -> busy=1 with col=0; 7th w_e ignored; col 0 reads
//     01,10,01,10,01,10 from the bottom; full=0.
//  4. Build a player1 rising diagonal (0,0),(1,1),(2,2),(3,3) with player0 filler; last drop at
//     col 3 -> win=1, winner=1 next cycle; win=0 before it.
//  5. Fill all 42 cells in a no-line pattern -> full=1 exactly one cycle after the 42nd w_e;
//     win=0; every col busy=1.
//  6. Mid-game, assert rst in the same cycle as w_e on col 2 -> board all 00, height=0, flags 0;
//     col 2 not written.

Source files
------------

// File: rtl/board_ctrl.sv
// Connect-4 style board store: gravity drop on the write strobe, per-move line detection,
// and a combinational cell read port for the renderer.
module board_ctrl #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] col,
    input  logic       player,
    input  logic       w_e,
    output logic       busy,
    output logic       win,
    output logic       winner,
    output logic       full,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [1:0] rd_cell
);

    localparam logic [3:0] ROWS_W = 4'(ROWS);
    localparam logic [3:0] COLS_W = 4'(COLS);
    localparam logic [6:0] CELLS  = 7'(ROWS * COLS);

    // Axis step vectors: horizontal, vertical, diagonal /, diagonal \.
    localparam int DR [4] = '{0, 1, 1, 1};
    localparam int DC [4] = '{1, 0, 1, -1};

    logic [1:0] board [ROWS][COLS];
    logic [3:0] height [COLS];
    logic [6:0] moves;

    logic       col_ok;
    logic [3:0] col_h;
    logic       accept;
    logic [1:0] piece;
    logic       hit;

    // Handshake: w_e is a one-cycle strobe with no back-pressure; a move is taken in any
    // cycle where w_e=1, busy=0 and win=0, otherwise the strobe is dropped with no effect.
    assign col_ok = {1'b0, col} < COLS_W;

    always_comb begin
        col_h = 4'd0;
        if (col_ok) begin
            col_h = height[col];
        end
    end

    assign busy   = !col_ok || (col_h == ROWS_W);
    assign accept = w_e && !busy && !win;
    assign piece  = player ? 2'b10 : 2'b01;

    // Judge the move on the pre-write board, counting the new cell as the mover's piece.
    always_comb begin
        int  rr;
        int  cc;
        int  cnt;
        bit  go_p;
        bit  go_n;
        hit  = 1'b0;
        rr   = 0;
        cc   = 0;
        cnt  = 0;
        go_p = 1'b0;
        go_n = 1'b0;
        for (int a = 0; a < 4; a++) begin
            cnt  = 1;
            go_p = 1'b1;
            go_n = 1'b1;
            for (int k = 1; k < WIN_LEN; k++) begin
                rr = int'(col_h) + k * DR[a];
                cc = int'(col) + k * DC[a];
                if (go_p && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && board[rr][cc] == piece)
                    cnt = cnt + 1;
                else
                    go_p = 1'b0;
                rr = int'(col_h) - k * DR[a];
                cc = int'(col) - k * DC[a];
                if (go_n && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && board[rr][cc] == piece)
                    cnt = cnt + 1;
                else
                    go_n = 1'b0;
            end
            if (cnt >= WIN_LEN) begin
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    board[r][c] <= 2'b00;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                height[c] <= 4'd0;
            end
            moves  <= 7'd0;
            win    <= 1'b0;
            winner <= 1'b0;
            full   <= 1'b0;
        end else if (accept) begin
            board[col_h[2:0]][col] <= piece;
            height[col]            <= col_h + 4'd1;
            moves                  <= moves + 7'd1;
            win                    <= win | hit;
            if (hit) begin
                winner <= player;
            end
            full <= (moves + 7'd1 == CELLS);
        end
    end

    always_comb begin
        rd_cell = 2'b00;
        if (({1'b0, rd_row} < ROWS_W) && ({1'b0, rd_col} < COLS_W)) begin
            rd_cell = board[rd_row][rd_col];
        end
    end

endmodule

// File: tb/tb_board_ctrl.sv
// Randomized and directed bench for board_ctrl with a window-scan reference model and a
// per-cycle expected queue consumed by an independent monitor.
module tb_board_ctrl;

    localparam int ROWS    = 6;
    localparam int COLS    = 7;
    localparam int WIN_LEN = 4;

    logic       clk;
    logic       rst;
    logic [2:0] col;
    logic       player;
    logic       w_e;
    logic       busy;
    logic       win;
    logic       winner;
    logic       full;
    logic [2:0] rd_row;
    logic [2:0] rd_col;
    logic [1:0] rd_cell;

    board_ctrl #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .col     (col),
        .player  (player),
        .w_e     (w_e),
        .busy    (busy),
        .win     (win),
        .winner  (winner),
        .full    (full),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_cell (rd_cell)
    );

    // clock / reset-free clock generator
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int mb [ROWS][COLS];
    int mh [COLS];
    int mmoves;
    bit mwin;
    bit mwinner;
    bit mfull;
    bit mknown;

    // expected word: [5] busy, [4] win, [3] winner, [2] full, [1:0] rd_cell
    logic [5:0] exp_q[$];
    int checks;
    int failures;
    int cyc;

    // A move wins when some length-WIN_LEN window through (r,c) is all the mover's pieces.
    function automatic bit line_through(int r, int c, int pc);
        int dr [4] = '{0, 1, 1, 1};
        int dc [4] = '{1, 0, 1, -1};
        for (int d = 0; d < 4; d++) begin
            for (int s = -(WIN_LEN - 1); s <= 0; s++) begin
                bit ok;
                ok = 1'b1;
                for (int k = 0; k < WIN_LEN; k++) begin
                    int rr;
                    int cc;
                    rr = r + (s + k) * dr[d];
                    cc = c + (s + k) * dc[d];
                    if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS)
                        ok = 1'b0;
                    else if (!(rr == r && cc == c) && mb[rr][cc] != pc)
                        ok = 1'b0;
                end
                if (ok) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mb[r][c] = 0;
        for (int c = 0; c < COLS; c++)
            mh[c] = 0;
        mmoves  = 0;
        mwin    = 1'b0;
        mwinner = 1'b0;
        mfull   = 1'b0;
    endtask

    // driver: one cycle of inputs, expected outputs for this cycle, then model update at the edge
    task automatic step(input int r, input int we, input int c, input int p, input int rr, input int rc);
        bit mbusy;
        int ecell;
        rst    = r[0];
        w_e    = we[0];
        col    = 3'(c);
        player = p[0];
        rd_row = 3'(rr);
        rd_col = 3'(rc);
        mbusy  = (c >= COLS) ? 1'b1 : (mh[c] == ROWS);
        ecell  = (rr < ROWS && rc < COLS) ? mb[rr][rc] : 0;
        if (mknown)
            exp_q.push_back({mbusy, mwin, mwinner, mfull, 2'(ecell)});
        if (r != 0) begin
            model_clear();
            mknown = 1'b1;
        end else if (mknown && we != 0 && !mbusy && !mwin) begin
            int row;
            bit hit;
            row = mh[c];
            hit = line_through(row, c, p + 1);
            mb[row][c] = p + 1;
            mh[c]      = mh[c] + 1;
            mmoves     = mmoves + 1;
            if (hit) begin
                mwin    = 1'b1;
                mwinner = p[0];
            end
            mfull = (mmoves == ROWS * COLS);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int c, input int rr, input int rc);
        step(0, 0, c, 0, rr, rc);
    endtask

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, expv);
        end
    endtask

    // monitor: every cycle the driver issued has one expected word waiting
    always @(negedge clk) begin
        logic [5:0] e;
        cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("busy",    {1'b0, busy},   {1'b0, e[5]});
            chk("win",     {1'b0, win},    {1'b0, e[4]});
            chk("winner",  {1'b0, winner}, {1'b0, e[3]});
            chk("full",    {1'b0, full},   {1'b0, e[2]});
            chk("rd_cell", rd_cell,        e[1:0]);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        mknown   = 1'b0;
        rst      = 1'b1;
        w_e      = 1'b0;
        col      = 3'd0;
        player   = 1'b0;
        rd_row   = 3'd0;
        rd_col   = 3'd0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();
        do_reset();

        // reset state: every cell, every column's busy, out-of-range reads
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                idle(c, r, c);
        for (int r = 0; r < 8; r++)
            idle(0, r, 7);

        // vertical win in col 3, then a frozen-board write
        for (int i = 0; i < 5; i++)
            step(0, 1, 3, 0, i, 3);
        for (int r = 0; r < ROWS; r++)
            idle(3, r, 3);

        // fill col 0 alternating, then the overflow attempt
        do_reset();
        for (int i = 0; i < 7; i++)
            step(0, 1, 0, i % 2, i, 0);
        for (int r = 0; r < ROWS; r++)
            idle(0, r, 0);

        // player1 rising diagonal with player0 filler
        begin
            int seq_c [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
            int seq_p [10] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 1};
            do_reset();
            for (int i = 0; i < 10; i++)
                step(0, 1, seq_c[i], seq_p[i], i % ROWS, i % COLS);
            for (int i = 0; i < 4; i++)
                idle(i, i, i);
        end

        // full board with no line: owner alternates per column and per row pair
        do_reset();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                step(0, 1, c, ((r >> 1) + c) & 1, r, c);
        for (int c = 0; c < 8; c++)
            idle(c, c % ROWS, c);
        step(0, 1, 4, 1, 5, 4);

        // reset wins over a simultaneous write
        do_reset();
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 2, 1, 0, 2);
        step(0, 1, 2, 0, 1, 2);
        step(1, 1, 2, 1, 2, 2);
        for (int r = 0; r < 3; r++)
            idle(2, r, 2);
        idle(1, 0, 1);

        // randomized play; restart games often once they are over
        for (int n = 0; n < 4000; n++) begin
            int r;
            if (mwin || mfull)
                r = ($urandom_range(0, 7) == 0) ? 1 : 0;
            else
                r = ($urandom_range(0, 299) == 0) ? 1 : 0;
            step(r, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
        end

        idle(0, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
